rv32i_instr_encoder: RTL and testbench

- Sequential RV32I instruction encoder: the inverse of the core's control/decode path.
- Accepts decoded instruction fields over a valid/ready handshake and emits legal 32-bit RV32I words as a write stream into instruction memory.
- Used for program loading and self-checking benches.
- Its alu_op encoding is identical to the core's 4-bit ALU control code, so decode(encode(x)) round-trips.

---
 rtl/rv32i_instr_encoder.sv | 191 +++++++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - RV32I field-bundle encoder streaming legal words into instruction memory
module rv32i_instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [3:0]        alu_op,
    input  logic [2:0]        f3,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words,
    output logic              err,
    output logic [7:0]        err_count,
    output logic              done
);
    localparam logic [ADDR_W-1:0] BASE_W  = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];

    localparam logic [3:0] K_R = 4'd0, K_I = 4'd1, K_LOAD = 4'd2, K_STORE = 4'd3, K_BRANCH = 4'd4;
    localparam logic [3:0] K_JAL = 4'd5, K_JALR = 4'd6, K_LUI = 4'd7, K_AUIPC = 4'd8;
    localparam logic [3:0] A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
    localparam logic [3:0] A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8;

    localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        legal;
    logic [31:0] word;
    logic [2:0]  f3_alu;
    logic [6:0]  funct7;
    logic        op_ok, is_shift, imm_i_ok, imm_b_ok, imm_j_ok;

    // Encoder: pure function of the bundle; legality and the word are computed together.
    always_comb begin
        op_ok    = (alu_op <= A_SRA);
        is_shift = (alu_op == A_SLL) || (alu_op == A_SRL) || (alu_op == A_SRA);
        funct7   = ((alu_op == A_SUB) || (alu_op == A_SRA)) ? 7'b0100000 : 7'b0000000;
        imm_i_ok = (&imm[31:11]) || (~|imm[31:11]);
        imm_b_ok = ((&imm[31:12]) || (~|imm[31:12])) && !imm[0];
        imm_j_ok = ((&imm[31:20]) || (~|imm[31:20])) && !imm[0];
        f3_alu   = 3'b000;
        case (alu_op)
            A_AND:        f3_alu = 3'b111;
            A_OR:         f3_alu = 3'b110;
            A_XOR:        f3_alu = 3'b100;
            A_SLT:        f3_alu = 3'b010;
            A_SLL:        f3_alu = 3'b001;
            A_SRL, A_SRA: f3_alu = 3'b101;
            default:      f3_alu = 3'b000;
        endcase
        legal = 1'b0;
        word  = 32'h0;
        case (kind)
            K_R: begin
                legal = op_ok;
                word  = {funct7, rs2, rs1, f3_alu, rd, OP_R};
            end
            K_I: begin
                legal = op_ok && (alu_op != A_SUB) && (is_shift ? (imm[31:5] == 27'd0) : imm_i_ok);
                word  = {(is_shift ? {funct7, imm[4:0]} : imm[11:0]), rs1, f3_alu, rd, OP_IMM};
            end
            K_LOAD: begin
                legal = imm_i_ok && (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                word  = {imm[11:0], rs1, f3, rd, OP_LOAD};
            end
            K_STORE: begin
                legal = imm_i_ok && (f3 <= 3'd2);
                word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            end
            K_BRANCH: begin
                legal = imm_b_ok && (f3 != 3'd2) && (f3 != 3'd3);
                word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            end
            K_JAL: begin
                legal = imm_j_ok;
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            K_JALR: begin
                legal = imm_i_ok;
                word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            end
            K_LUI: begin
                legal = (imm[11:0] == 12'd0);
                word  = {imm[31:12], rd, OP_LUI};
            end
            K_AUIPC: begin
                legal = (imm[11:0] == 12'd0);
                word  = {imm[31:12], rd, OP_AUIPC};
            end
            default: begin
                legal = 1'b0;
                word  = 32'h0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        words_d     = words_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    next_addr_d = BASE_W;
                    words_d     = '0;
                    err_d       = 1'b0;
                    err_count_d = 8'd0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (legal) begin
                        we_d        = 1'b1;
                        waddr_d     = next_addr_q;
                        wdata_d     = word;
                        next_addr_d = next_addr_q + 1'b1;
                        words_d     = words_q + 1'b1;
                        // Reaching DEPTH closes the session on the same edge as the last transfer.
                        if (words_d == DEPTH_W) state_d = S_DONE;
                    end else begin
                        err_d = 1'b1;
                        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    end
                end
                if (finish) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            next_addr_q <= BASE_W;
            words_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            words_q     <= words_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign words      = words_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - self-checking bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;
    localparam int AW   = 3;
    localparam int DEP  = 4;
    localparam int BASE = 6;

    logic          clk = 1'b0;
    logic          rst_n, start, finish, in_valid, in_ready;
    logic [3:0]    kind, alu_op;
    logic [2:0]    f3;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   words;
    logic          err;
    logic [7:0]    err_count;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_state, m_words, m_next, m_errc;
    logic        m_err, m_we;
    logic [31:0] m_waddr, m_wdata;

    rv32i_instr_encoder #(.ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .kind(kind), .alu_op(alu_op),
        .f3(f3), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .words(words), .err(err), .err_count(err_count), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary (elapsed %0t, limit 2000000)", $time);
        $fatal(1, "timeout");
    end

    // Reference encoder built straight from the ISA field placement rules.
    function automatic logic [32:0] ref_enc(input int k, input int op, input int fn3, input int rdv,
                                             input int rs1v, input int rs2v, input logic [31:0] iv);
        int          s;
        int          f3t[9];
        logic        ok;
        logic [31:0] w;
        f3t = '{0, 0, 7, 6, 4, 2, 1, 5, 5};
        s   = $signed(iv);
        ok  = 1'b1;
        w   = 32'h0;
        case (k)
            0: if (op > 8) ok = 1'b0;
               else w = ((op == 1 || op == 8) ? 32'h4000_0000 : 32'h0) | (rs2v << 20) | (rs1v << 15) | (f3t[op] << 12) | (rdv << 7) | 32'h33;
            1: if (op > 8 || op == 1) ok = 1'b0;
               else if (op >= 6) begin
                   if (iv > 31) ok = 1'b0;
                   else w = ((op == 8) ? 32'h4000_0000 : 32'h0) | (iv << 20) | (rs1v << 15) | (f3t[op] << 12) | (rdv << 7) | 32'h13;
               end
               else if (s < -2048 || s > 2047) ok = 1'b0;
               else w = ((iv & 32'hfff) << 20) | (rs1v << 15) | (f3t[op] << 12) | (rdv << 7) | 32'h13;
            2: if (fn3 == 3 || fn3 == 6 || fn3 == 7 || s < -2048 || s > 2047) ok = 1'b0;
               else w = ((iv & 32'hfff) << 20) | (rs1v << 15) | (fn3 << 12) | (rdv << 7) | 32'h03;
            3: if (fn3 > 2 || s < -2048 || s > 2047) ok = 1'b0;
               else w = (((iv >> 5) & 32'h7f) << 25) | (rs2v << 20) | (rs1v << 15) | (fn3 << 12) | ((iv & 32'h1f) << 7) | 32'h23;
            4: if (fn3 == 2 || fn3 == 3 || s < -4096 || s > 4095 || iv[0]) ok = 1'b0;
               else w = (((iv >> 12) & 32'h1) << 31) | (((iv >> 5) & 32'h3f) << 25) | (rs2v << 20) | (rs1v << 15) | (fn3 << 12)
                        | (((iv >> 1) & 32'hf) << 8) | (((iv >> 11) & 32'h1) << 7) | 32'h63;
            5: if (s < -1048576 || s > 1048575 || iv[0]) ok = 1'b0;
               else w = (((iv >> 20) & 32'h1) << 31) | (((iv >> 1) & 32'h3ff) << 21) | (((iv >> 11) & 32'h1) << 20)
                        | (((iv >> 12) & 32'hff) << 12) | (rdv << 7) | 32'h6f;
            6: if (s < -2048 || s > 2047) ok = 1'b0;
               else w = ((iv & 32'hfff) << 20) | (rs1v << 15) | (rdv << 7) | 32'h67;
            7, 8: if ((iv & 32'hfff) != 0) ok = 1'b0;
               else w = (iv & 32'hffff_f000) | (rdv << 7) | ((k == 7) ? 32'h37 : 32'h17);
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    function automatic logic [31:0] rand_imm();
        int bnd[15];
        bnd = '{2047, 2048, -2048, -2049, 4095, 4094, -4096, -4098, 4096,
                1048574, 1048576, -1048576, -1048578, 32, 31};
        case ($urandom_range(0, 7))
            0:       return 32'($urandom_range(0, 31));
            1:       return 32'(int'($urandom_range(0, 4095)) - 2048);
            2:       return 32'(bnd[$urandom_range(0, 14)]);
            3:       return $urandom & 32'hFFFF_F000;
            4:       return $urandom;
            5:       return 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
            6:       return 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input int op, input int fn3, input int rdv, input int rs1v, input int rs2v, input logic [31:0] iv);
        kind = 4'(k); alu_op = 4'(op); f3 = 3'(fn3); rd = 5'(rdv); rs1 = 5'(rs1v); rs2 = 5'(rs2v); imm = iv;
    endtask

    task automatic new_session();
        in_valid = 0; start = 0; finish = 1; tick();
        finish = 0; start = 1; tick();
        start = 0;
    endtask

    // Cycle-level expectation of session bookkeeping, advanced with the inputs present before an edge.
    task automatic model_edge();
        logic [32:0] r;
        if (!rst_n) begin
            m_state = 0; m_words = 0; m_next = BASE; m_err = 0; m_errc = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
        end else begin
            m_we = 0;
            if (m_state == 1) begin
                if (in_valid) begin
                    r = ref_enc(kind, alu_op, f3, rd, rs1, rs2, imm);
                    if (r[32]) begin
                        m_we = 1; m_waddr = m_next; m_wdata = r[31:0];
                        m_next = (m_next + 1) % (1 << AW);
                        m_words++;
                        if (m_words == DEP) m_state = 2;
                    end else begin
                        m_err = 1;
                        if (m_errc < 255) m_errc++;
                    end
                end
                if (finish) m_state = 2;
            end else if (start) begin
                m_state = 1; m_words = 0; m_next = BASE; m_err = 0; m_errc = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; finish = 0; in_valid = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        n_checks++; if ({imem_we, imem_addr, imem_wdata, words, err, err_count, done, in_ready} !== '0) begin n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {imem_we, imem_addr, imem_wdata, words, err, err_count, done, in_ready}); end
        rst_n = 1; drive(1, 0, 0, 1, 0, 0, 5); in_valid = 1;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", in_ready); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b want 0", imem_we); end
        n_checks++; if (words !== '0) begin n_fail++; $display("FAIL idle_words: got %0d want 0", words); end
        in_valid = 0;
    endtask

    task automatic test_single();
        start = 1; tick(); start = 0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", in_ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_done: got %b want 0", done); end
        drive(1, 0, 0, 1, 0, 0, 5); in_valid = 1; tick(); in_valid = 0;
        n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", imem_we); end
        n_checks++; if (imem_addr !== AW'(BASE)) begin n_fail++; $display("FAIL single_addr: got %0d want %0d", imem_addr, BASE); end
        n_checks++; if (imem_wdata !== 32'h0050_0093) begin n_fail++; $display("FAIL single_wdata: got %h want 00500093", imem_wdata); end
        n_checks++; if (words !== 4'd1) begin n_fail++; $display("FAIL single_words: got %0d want 1", words); end
        tick();
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL single_we_pulse: got %b want 0", imem_we); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_no_valid: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        new_session();
        drive(0, 1, 0, 3, 1, 2, 0); in_valid = 1; tick();
        n_checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, AW'(BASE), 32'h4020_81B3}) begin n_fail++;
            $display("FAIL b2b_first: got we=%b addr=%0d data=%h want we=1 addr=%0d data=402081b3", imem_we, imem_addr, imem_wdata, BASE); end
        drive(4, 0, 0, 0, 1, 2, -8); tick(); in_valid = 0;
        n_checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, AW'(BASE + 1), 32'hFE20_8CE3}) begin n_fail++;
            $display("FAIL b2b_second: got we=%b addr=%0d data=%h want we=1 addr=%0d data=fe208ce3", imem_we, imem_addr, imem_wdata, (BASE + 1) % 8); end
        n_checks++; if (words !== 4'd2) begin n_fail++; $display("FAIL b2b_words: got %0d want 2", words); end
        tick();
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_we: got %b want 0", imem_we); end
    endtask

    task automatic test_illegal();
        new_session();
        drive(1, 1, 0, 1, 1, 0, 5); in_valid = 1; tick();
        n_checks++; if ({imem_we, err, err_count} !== {1'b0, 1'b1, 8'd1}) begin n_fail++;
            $display("FAIL illegal_subi: got we=%b err=%b cnt=%0d want we=0 err=1 cnt=1", imem_we, err, err_count); end
        drive(4, 0, 0, 0, 1, 2, 3); tick(); in_valid = 0;
        n_checks++; if ({imem_we, err, err_count, words} !== {1'b0, 1'b1, 8'd2, 4'd0}) begin n_fail++;
            $display("FAIL illegal_branch: got we=%b err=%b cnt=%0d words=%0d want 0 1 2 0", imem_we, err, err_count, words); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_depth();
        new_session();
        in_valid = 1;
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, 0, c + 1, 0, 0, c); tick();
            if (c < DEP) begin
                n_checks++; if ({imem_we, imem_addr, imem_wdata, words} !== {1'b1, AW'(BASE + c), 32'((c << 20) | ((c + 1) << 7) | 'h13), 4'(c + 1)}) begin n_fail++;
                    $display("FAIL depth_write%0d: got we=%b addr=%0d data=%h words=%0d want addr=%0d words=%0d", c, imem_we, imem_addr, imem_wdata, words, (BASE + c) % 8, c + 1); end
            end else begin
                n_checks++; if ({imem_we, words} !== {1'b0, 4'(DEP)}) begin n_fail++;
                    $display("FAIL depth_extra%0d: got we=%b words=%0d want we=0 words=%0d", c, imem_we, words, DEP); end
            end
            if (c >= DEP - 1) begin
                n_checks++; if ({done, in_ready} !== 2'b10) begin n_fail++;
                    $display("FAIL depth_done%0d: got done=%b ready=%b want 1 0", c, done, in_ready); end
            end
        end
        in_valid = 0;
    endtask

    task automatic test_finish();
        new_session();
        drive(1, 0, 0, 2, 0, 0, 1); in_valid = 1; tick();
        drive(9, 0, 0, 0, 0, 0, 0); tick(); in_valid = 0;
        start = 1; tick(); start = 0;
        n_checks++; if ({words, err, in_ready} !== {4'd1, 1'b1, 1'b1}) begin n_fail++;
            $display("FAIL start_in_load: got words=%0d err=%b ready=%b want 1 1 1", words, err, in_ready); end
        drive(7, 0, 0, 5, 0, 0, 32'h1234_5000); in_valid = 1; finish = 1; tick(); in_valid = 0; finish = 0;
        n_checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, AW'(BASE + 1), 32'h1234_52B7}) begin n_fail++;
            $display("FAIL finish_lui: got we=%b addr=%0d data=%h want we=1 addr=%0d data=123452b7", imem_we, imem_addr, imem_wdata, (BASE + 1) % 8); end
        n_checks++; if ({done, in_ready, words} !== {1'b1, 1'b0, 4'd2}) begin n_fail++;
            $display("FAIL finish_done: got done=%b ready=%b words=%0d want 1 0 2", done, in_ready, words); end
        start = 1; tick(); start = 0;
        n_checks++; if ({words, err, err_count, done, in_ready} !== {4'd0, 1'b0, 8'd0, 1'b0, 1'b1}) begin n_fail++;
            $display("FAIL restart_clear: got words=%0d err=%b cnt=%0d done=%b ready=%b want 0 0 0 0 1", words, err, err_count, done, in_ready); end
        drive(1, 0, 0, 1, 0, 0, 5); in_valid = 1; tick(); in_valid = 0;
        n_checks++; if ({imem_we, imem_addr, words} !== {1'b1, AW'(BASE), 4'd1}) begin n_fail++;
            $display("FAIL restart_addr: got we=%b addr=%0d words=%0d want 1 %0d 1", imem_we, imem_addr, words, BASE); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 1, 0, 0, 7); in_valid = 1; tick();
        n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL mid_pre_we: got %b want 1", imem_we); end
        rst_n = 0; tick();
        n_checks++; if ({imem_we, imem_addr, imem_wdata, words, err, err_count, done, in_ready} !== '0) begin n_fail++;
            $display("FAIL mid_reset_outputs: got %h want 0", {imem_we, imem_addr, imem_wdata, words, err, err_count, done, in_ready}); end
        rst_n = 1; tick(); tick();
        n_checks++; if ({imem_we, in_ready, words} !== '0) begin n_fail++;
            $display("FAIL mid_idle_ignored: got we=%b ready=%b words=%0d want 0 0 0", imem_we, in_ready, words); end
        in_valid = 0; start = 1; tick(); start = 0;
        in_valid = 1; rst_n = 0; tick(); in_valid = 0; rst_n = 1;
        n_checks++; if ({imem_we, in_ready, words} !== '0) begin n_fail++;
            $display("FAIL reset_with_xfer: got we=%b ready=%b words=%0d want 0 0 0", imem_we, in_ready, words); end
    endtask

    task automatic test_err_saturate();
        new_session();
        drive(15, 0, 0, 0, 0, 0, 0); in_valid = 1;
        repeat (254) tick();
        n_checks++; if (err_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", err_count); end
        tick();
        n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", err_count); end
        repeat (5) tick();
        in_valid = 0;
        n_checks++; if ({err_count, err, words, imem_we} !== {8'd255, 1'b1, 4'd0, 1'b0}) begin n_fail++;
            $display("FAIL sat_hold: got cnt=%0d err=%b words=%0d we=%b want 255 1 0 0", err_count, err, words, imem_we); end
    endtask

    task automatic test_random();
        rst_n = 0; start = 0; finish = 0; in_valid = 0;
        model_edge(); tick();
        rst_n = 1;
        for (int i = 0; i < 4000; i++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            start    = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            finish   = ($urandom_range(0, 31) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 7),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), rand_imm());
            model_edge();
            tick();
            n_checks++; if (imem_we !== m_we) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b want %b", i, imem_we, m_we); end
            n_checks++; if (in_ready !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, m_state == 1); end
            n_checks++; if (done !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_done[%0d]: got %b want %b", i, done, m_state == 2); end
            n_checks++; if (words !== 4'(m_words)) begin n_fail++; $display("FAIL rnd_words[%0d]: got %0d want %0d", i, words, m_words); end
            n_checks++; if ({err, err_count} !== {m_err, 8'(m_errc)}) begin n_fail++;
                $display("FAIL rnd_err[%0d]: got err=%b cnt=%0d want err=%b cnt=%0d", i, err, err_count, m_err, m_errc); end
            if (m_we) begin
                n_checks++; if ({imem_addr, imem_wdata} !== {AW'(m_waddr), m_wdata}) begin n_fail++;
                    $display("FAIL rnd_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h (kind=%0d op=%0d f3=%0d imm=%h)",
                             i, imem_addr, imem_wdata, m_waddr, m_wdata, kind, alu_op, f3, imm); end
            end
        end
        rst_n = 1; start = 0; finish = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_depth();
        test_finish();
        test_reset_mid();
        test_err_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
